// File: rtl/s2mm_lite_engine.sv
// Lightweight S2MM datamover: 72-bit datamover commands plus an AXIS data stream are turned
// into AXI4 INCR write bursts (one outstanding), with an 8-bit datamover status per command.
// Optional feature macro: S2MM_KEEP_STRB_EN (wstrb follows tkeep on consumed beats).
module s2mm_lite_engine #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned AWID_VAL   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_s2mm_cmd_tvalid,
    output logic                  s_axis_s2mm_cmd_tready,
    input  logic [71:0]           s_axis_s2mm_cmd_tdata,
    input  logic [63:0]           s_axis_s2mm_tdata,
    input  logic [7:0]            s_axis_s2mm_tkeep,
    input  logic                  s_axis_s2mm_tlast,
    input  logic                  s_axis_s2mm_tvalid,
    output logic                  s_axis_s2mm_tready,
    output logic [7:0]            m_axis_s2mm_sts_tdata,
    output logic                  m_axis_s2mm_sts_tvalid,
    output logic                  m_axis_s2mm_sts_tkeep,
    output logic                  m_axis_s2mm_sts_tlast,
    input  logic                  m_axis_s2mm_sts_tready,
    output logic [ID_WIDTH-1:0]   m_axi_s2mm_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_s2mm_awaddr,
    output logic [7:0]            m_axi_s2mm_awlen,
    output logic [2:0]            m_axi_s2mm_awsize,
    output logic [1:0]            m_axi_s2mm_awburst,
    output logic [3:0]            m_axi_s2mm_awcache,
    output logic [2:0]            m_axi_s2mm_awprot,
    output logic                  m_axi_s2mm_awvalid,
    input  logic                  m_axi_s2mm_awready,
    output logic [63:0]           m_axi_s2mm_wdata,
    output logic [7:0]            m_axi_s2mm_wstrb,
    output logic                  m_axi_s2mm_wlast,
    output logic                  m_axi_s2mm_wvalid,
    input  logic                  m_axi_s2mm_wready,
    input  logic [1:0]            m_axi_s2mm_bresp,
    input  logic                  m_axi_s2mm_bvalid,
    output logic                  m_axi_s2mm_bready
);

    typedef enum logic [2:0] {StIdle, StCheck, StAw, StW, StB, StSts} state_e;

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [19:0]           remaining_q;
    logic [8:0]            len_q;
    logic [8:0]            beat_q;
    logic [3:0]            tag_q;
    logic                  bad_len_q;
    logic                  type_q;
    logic                  interr_q;
    logic                  decerr_q;
    logic                  slverr_q;
    logic                  pad_q;
    logic                  cmd_tready_q;
    logic                  awvalid_q;
    logic                  bready_q;
    logic                  sts_tvalid_q;
    logic [7:0]            awlen_q;
    logic [7:0]            sts_q;

    logic                  last_in_burst;
    logic                  final_beat;
    logic                  w_active;
    logic                  w_fire;
    logic                  s_fire;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [19:0]           rem_nx;
    logic [8:0]            len_first;
    logic [8:0]            len_next;
    logic                  slverr_nx;
    logic                  decerr_nx;
    logic [7:0]            keep_strb;
    logic                  unused_cmd;

    // Burst length limited by MAX_BURST, beats left, and beats left before the next 4 KB page.
    function automatic logic [8:0] burst_len(input logic [11:0] page_off, input logic [19:0] rem);
        logic [12:0] page_beats;
        logic [19:0] len;
        page_beats = (13'd4096 - {1'b0, page_off}) >> 3;
        len = 20'(MAX_BURST);
        if (rem < len) len = rem;
        if ({7'd0, page_beats} < len) len = {7'd0, page_beats};
        return 9'(len);
    endfunction

    assign unused_cmd = ^{s_axis_s2mm_cmd_tdata[71:68], s_axis_s2mm_cmd_tdata[31:24]};

`ifdef S2MM_KEEP_STRB_EN
    assign keep_strb = s_axis_s2mm_tkeep;
`else
    logic unused_keep;
    assign unused_keep = ^s_axis_s2mm_tkeep;
    assign keep_strb   = 8'hFF;
`endif

    assign last_in_burst = (beat_q == len_q - 9'd1);
    assign final_beat    = last_in_burst && (remaining_q == {11'd0, len_q});
    assign w_active      = (state == StW) && !pad_q;

    // After an early tlast the rest of the command is padded without touching the stream.
    assign m_axi_s2mm_wvalid  = (state == StW) && (pad_q || s_axis_s2mm_tvalid);
    assign s_axis_s2mm_tready = w_active && m_axi_s2mm_wready;
    assign w_fire             = m_axi_s2mm_wvalid && m_axi_s2mm_wready;
    assign s_fire             = w_fire && !pad_q;
    assign m_axi_s2mm_wlast   = (state == StW) && last_in_burst;
    assign m_axi_s2mm_wdata   = w_active ? s_axis_s2mm_tdata : 64'd0;
    assign m_axi_s2mm_wstrb   = w_active ? keep_strb : 8'h00;

    assign addr_nx   = addr_q + ADDR_WIDTH'({len_q, 3'b000});
    assign rem_nx    = remaining_q - {11'd0, len_q};
    assign len_first = burst_len(addr_q[11:0], remaining_q);
    assign len_next  = burst_len(addr_nx[11:0], rem_nx);
    assign slverr_nx = slverr_q | (m_axi_s2mm_bresp == 2'b10);
    assign decerr_nx = decerr_q | (m_axi_s2mm_bresp == 2'b11);

    // Command sequencing: accept, validate, then AW/W/B per burst until done, then status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            addr_q       <= '0;
            remaining_q  <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            tag_q        <= '0;
            bad_len_q    <= 1'b0;
            type_q       <= 1'b0;
            interr_q     <= 1'b0;
            decerr_q     <= 1'b0;
            slverr_q     <= 1'b0;
            pad_q        <= 1'b0;
            cmd_tready_q <= 1'b0;
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            sts_tvalid_q <= 1'b0;
            awlen_q      <= '0;
            sts_q        <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    cmd_tready_q <= 1'b1;
                    if (s_axis_s2mm_cmd_tvalid && cmd_tready_q) begin
                        cmd_tready_q <= 1'b0;
                        addr_q       <= ADDR_WIDTH'(s_axis_s2mm_cmd_tdata[63:32]);
                        tag_q        <= s_axis_s2mm_cmd_tdata[67:64];
                        remaining_q  <= s_axis_s2mm_cmd_tdata[22:3];
                        bad_len_q    <= (s_axis_s2mm_cmd_tdata[22:0] == 23'd0) ||
                                        (s_axis_s2mm_cmd_tdata[2:0] != 3'd0);
                        type_q       <= s_axis_s2mm_cmd_tdata[23];
                        interr_q     <= 1'b0;
                        decerr_q     <= 1'b0;
                        slverr_q     <= 1'b0;
                        pad_q        <= 1'b0;
                        state        <= StCheck;
                    end
                end
                StCheck: begin
                    if (bad_len_q || (addr_q[2:0] != 3'd0) || !type_q) begin
                        interr_q     <= 1'b1;
                        sts_q        <= {4'b0001, tag_q};
                        sts_tvalid_q <= 1'b1;
                        state        <= StSts;
                    end else begin
                        len_q     <= len_first;
                        awlen_q   <= 8'(len_first - 9'd1);
                        beat_q    <= '0;
                        awvalid_q <= 1'b1;
                        state     <= StAw;
                    end
                end
                StAw: begin
                    if (m_axi_s2mm_awready) begin
                        awvalid_q <= 1'b0;
                        state     <= StW;
                    end
                end
                StW: begin
                    if (w_fire) begin
                        if (s_fire && s_axis_s2mm_tlast && !final_beat) begin
                            interr_q <= 1'b1;
                            pad_q    <= 1'b1;
                        end
                        if (s_fire && !s_axis_s2mm_tlast && final_beat) begin
                            interr_q <= 1'b1;
                        end
                        if (last_in_burst) begin
                            beat_q   <= '0;
                            bready_q <= 1'b1;
                            state    <= StB;
                        end else begin
                            beat_q <= beat_q + 9'd1;
                        end
                    end
                end
                StB: begin
                    if (m_axi_s2mm_bvalid) begin
                        bready_q    <= 1'b0;
                        slverr_q    <= slverr_nx;
                        decerr_q    <= decerr_nx;
                        addr_q      <= addr_nx;
                        remaining_q <= rem_nx;
                        if (rem_nx != 20'd0) begin
                            len_q     <= len_next;
                            awlen_q   <= 8'(len_next - 9'd1);
                            awvalid_q <= 1'b1;
                            state     <= StAw;
                        end else begin
                            sts_q        <= {~(interr_q | slverr_nx | decerr_nx), slverr_nx,
                                             decerr_nx, interr_q, tag_q};
                            sts_tvalid_q <= 1'b1;
                            state        <= StSts;
                        end
                    end
                end
                StSts: begin
                    if (m_axis_s2mm_sts_tready) begin
                        sts_tvalid_q <= 1'b0;
                        interr_q     <= 1'b0;
                        decerr_q     <= 1'b0;
                        slverr_q     <= 1'b0;
                        pad_q        <= 1'b0;
                        cmd_tready_q <= 1'b1;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign s_axis_s2mm_cmd_tready = cmd_tready_q;
    assign m_axis_s2mm_sts_tdata  = sts_q;
    assign m_axis_s2mm_sts_tvalid = sts_tvalid_q;
    assign m_axis_s2mm_sts_tkeep  = sts_tvalid_q;
    assign m_axis_s2mm_sts_tlast  = sts_tvalid_q;
    assign m_axi_s2mm_awid        = ID_WIDTH'(AWID_VAL);
    assign m_axi_s2mm_awaddr      = addr_q;
    assign m_axi_s2mm_awlen       = awlen_q;
    assign m_axi_s2mm_awsize      = 3'b011;
    assign m_axi_s2mm_awburst     = 2'b01;
    assign m_axi_s2mm_awcache     = 4'b0011;
    assign m_axi_s2mm_awprot      = 3'b000;
    assign m_axi_s2mm_awvalid     = awvalid_q;
    assign m_axi_s2mm_bready      = bready_q;

endmodule
